mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 16 (range 1..255): max debug-owned cycles before forced release when CPU is waiting.
REQ-002 Parameter TIMEOUT, default 255 (range 2..255): max cycles any owner holds a grant (used only with watchdog, REQ-030).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 cpu_req  input  1  CPU requests the shared memory block (abus/mbus).
REQ-006 cpu_done  input  1  CPU releases ownership; sampled only while cpu_gnt=1.
REQ-007 dbg_req  input  1  debug/loader port requests the memory block.
REQ-008 dbg_done  input  1  debug port releases ownership; sampled only while dbg_gnt=1.
REQ-009 cpu_gnt  output  1  registered; CPU may drive abus/mbus.
REQ-010 dbg_gnt  output  1  registered; debug port may drive abus/mbus.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 dbg_preempt  output  1  one-cycle pulse when debug ownership is revoked by the burst limit.
REQ-013 timeout_err  output  1  sticky watchdog flag (constant 0 when watchdog is compiled out).

Function
REQ-014 The FSM SHALL have states IDLE, CPU, DBG, HANDOVER; cpu_gnt=1 only in CPU, dbg_gnt=1 only in DBG; both grants SHALL never be high together.
REQ-015 IDLE: cpu_req only -> CPU; dbg_req only -> DBG; neither -> stay.
REQ-016 IDLE with both requests SHALL grant the requester not served last (last_owner flag); last_owner resets to DBG, so the CPU wins the first tie.
REQ-017 Grant latency SHALL be exactly one clock: request sampled high at edge N in IDLE -> grant high from edge N to the next exit edge.
REQ-018 CPU state: cpu_done=1 or cpu_req=0 at an edge -> HANDOVER; last_owner<=CPU.
REQ-019 DBG state: dbg_done=1 or dbg_req=0 at an edge -> HANDOVER; last_owner<=DBG.
REQ-020 An 8-bit burst counter SHALL load 1 on entry to DBG, increment each DBG cycle, and saturate at 255.
REQ-021 In DBG, burst count == BURST_MAX with cpu_req=1 at an edge -> HANDOVER and dbg_preempt pulses high for that one following cycle; with cpu_req=0, DBG continues.
REQ-022 If dbg_done and the burst preempt condition coincide, the transition SHALL be a normal release (no dbg_preempt pulse).
REQ-023 HANDOVER SHALL last exactly one cycle with both grants low (tristate bus turnaround), then -> IDLE unconditionally; requests during HANDOVER are ignored, not lost (re-sampled in IDLE).
REQ-024 Minimum gap between one owner's grant fall and the next grant rise SHALL be two cycles (HANDOVER + IDLE).
REQ-025 Requests dropped before grant SHALL cancel cleanly; no request latching.

Reset
REQ-026 rstn=0 SHALL immediately (asynchronously) force state=IDLE, cpu_gnt=0, dbg_gnt=0, busy=0, dbg_preempt=0, timeout_err=0, burst count=0, watchdog count=0, last_owner=DBG.
REQ-027 Reset asserted mid-ownership SHALL drop the grant without passing through HANDOVER.
REQ-028 Deassertion of rstn SHALL be synchronized to clk; the first grant is possible at the second rising edge after release.

Configuration
REQ-029 Macro MEM_ARB_WATCHDOG_EN selects the ownership watchdog.
REQ-030 Defined: an 8-bit counter loads 1 on entry to CPU or DBG and increments each owned cycle; reaching TIMEOUT while still owned forces HANDOVER at that edge and sets timeout_err=1 until reset; a watchdog release updates last_owner like a normal release.
REQ-031 Not defined: no watchdog logic; ownership is unbounded except by REQ-021; timeout_err tied to 0.

Verification
REQ-032 Reset, then cpu_req=1 at edge 1 -> cpu_gnt=1 after edge 1; cpu_done=1 at edge 5 -> cpu_gnt=0, busy=1 (HANDOVER), IDLE at edge 6.
REQ-033 Both requests held, owners always release after 3 cycles -> grant order CPU, DBG, CPU, DBG; 2-cycle gap between grants; never both grants high.
REQ-034 BURST_MAX=4, dbg owns, cpu_req rises during DBG -> dbg_gnt falls after 4th DBG cycle, dbg_preempt pulses once, cpu_gnt rises 2 cycles later.
REQ-035 rstn pulsed low mid-DBG -> dbg_gnt=0 immediately, no dbg_preempt, state IDLE, next tie granted to CPU.
REQ-036 With MEM_ARB_WATCHDOG_EN, TIMEOUT=8, cpu holds cpu_req without cpu_done -> cpu_gnt falls after 8 owned cycles, timeout_err=1 sticky until reset; without the macro, cpu_gnt stays high for 300 cycles and timeout_err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (CPU / debug) shared-memory ownership arbiter
// Optional ownership watchdog compiled in with `define MEM_ARB_WATCHDOG_EN.
module mem_arbiter #(
   parameter int BURST_MAX = 16,
   parameter int TIMEOUT   = 255
) (
   input  logic clk,
   input  logic rstn,
   input  logic cpu_req,
   input  logic cpu_done,
   input  logic dbg_req,
   input  logic dbg_done,
   output logic cpu_gnt,
   output logic dbg_gnt,
   output logic busy,
   output logic dbg_preempt,
   output logic timeout_err
);

   if (BURST_MAX < 1 || BURST_MAX > 255 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
      $error("mem_arbiter: BURST_MAX must be 1..255 and TIMEOUT 2..255");
   end

   localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

   // One-hot so each grant is a state flop with no decode logic behind it.
   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_CPU  = 4'b0010,
      S_DBG  = 4'b0100,
      S_HND  = 4'b1000
   } state_t;

   state_t     state, next_state;
   logic       rst_sync;
   logic       last_dbg;
   logic [7:0] burst_cnt;
   logic       cpu_rel, dbg_rel, burst_hit, wd_hit, preempt_set;

   // Reset asserts asynchronously but releases one edge after rstn rises.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) rst_sync <= 1'b0;
      else       rst_sync <= 1'b1;
   end

   assign cpu_rel   = cpu_done | ~cpu_req;
   assign dbg_rel   = dbg_done | ~dbg_req;
   assign burst_hit = (burst_cnt >= BURST_LIM) & cpu_req;

`ifdef MEM_ARB_WATCHDOG_EN
   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);
   logic [7:0] wd_cnt;
   logic       owner_rel;

   assign wd_hit    = (wd_cnt == TIMEOUT_LIM);
   assign owner_rel = ((state == S_CPU) & cpu_rel) | ((state == S_DBG) & dbg_rel);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wd_cnt      <= 8'd0;
         timeout_err <= 1'b0;
      end else if (!rst_sync) begin
         wd_cnt      <= 8'd0;
         timeout_err <= 1'b0;
      end else begin
         if (next_state == S_CPU || next_state == S_DBG)
            wd_cnt <= (state == next_state) ? wd_cnt + 8'd1 : 8'd1;
         else
            wd_cnt <= 8'd0;
         if (wd_hit && !owner_rel)
            timeout_err <= 1'b1;
      end
   end
`else
   assign wd_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)          state <= S_IDLE;
      else if (!rst_sync) state <= S_IDLE;
      else                state <= next_state;
   end

   always_comb begin
      next_state  = state;
      preempt_set = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (cpu_req && dbg_req) next_state = last_dbg ? S_CPU : S_DBG;
            else if (cpu_req)       next_state = S_CPU;
            else if (dbg_req)       next_state = S_DBG;
         end
         S_CPU: begin
            if (cpu_rel || wd_hit) next_state = S_HND;
         end
         S_DBG: begin
            // A voluntary release takes priority, so it never reports a preempt.
            if (dbg_rel) begin
               next_state = S_HND;
            end else if (burst_hit || wd_hit) begin
               next_state  = S_HND;
               preempt_set = burst_hit;
            end
         end
         S_HND:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      cpu_gnt = (state == S_CPU);
      dbg_gnt = (state == S_DBG);
      busy    = (state != S_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_dbg    <= 1'b1;
         burst_cnt   <= 8'd0;
         dbg_preempt <= 1'b0;
      end else if (!rst_sync) begin
         last_dbg    <= 1'b1;
         burst_cnt   <= 8'd0;
         dbg_preempt <= 1'b0;
      end else begin
         dbg_preempt <= preempt_set;
         if (state == S_CPU && next_state == S_HND) last_dbg <= 1'b0;
         if (state == S_DBG && next_state == S_HND) last_dbg <= 1'b1;
         if (next_state == S_DBG) begin
            if (state != S_DBG)          burst_cnt <= 8'd1;
            else if (burst_cnt != 8'hff) burst_cnt <= burst_cnt + 8'd1;
         end else begin
            burst_cnt <= 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rstn, cpu_req, cpu_done, dbg_req, dbg_done;
   logic cpu_gnt, dbg_gnt, busy, dbg_preempt, timeout_err;
   int   n_checks = 0;
   int   n_errors = 0;

   mem_arbiter #(.BURST_MAX(4), .TIMEOUT(8)) dut (
      .clk(clk), .rstn(rstn),
      .cpu_req(cpu_req), .cpu_done(cpu_done),
      .dbg_req(dbg_req), .dbg_done(dbg_done),
      .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt), .busy(busy),
      .dbg_preempt(dbg_preempt), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0; cpu_req = 1'b0; cpu_done = 1'b0; dbg_req = 1'b0; dbg_done = 1'b0;
      step(); step();
      check("rst_cpu_gnt", cpu_gnt, 0);
      check("rst_dbg_gnt", dbg_gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_preempt", dbg_preempt, 0);
      check("rst_timeout", timeout_err, 0);

      // first grant only at the second edge after release
      cpu_req = 1'b1; rstn = 1'b1;
      step();
      check("sync_edge1_cpu_gnt", cpu_gnt, 0);
      step();
      check("cpu_grant", cpu_gnt, 1);
      check("cpu_grant_busy", busy, 1);
      check("cpu_grant_dbg_gnt", dbg_gnt, 0);
      step(); step();
      cpu_done = 1'b1;
      step();
      check("cpu_rel_gnt", cpu_gnt, 0);
      check("cpu_rel_handover_busy", busy, 1);
      cpu_done = 1'b0; cpu_req = 1'b0;
      step();
      check("cpu_rel_idle_busy", busy, 0);

      // both requesting; CPU served last, so order is DBG, CPU, DBG, CPU
      cpu_req = 1'b1; dbg_req = 1'b1;
      for (int r = 0; r < 4; r++) begin
         for (int c = 1; c <= 5; c++) begin
            step();
            check($sformatf("alt_r%0d_c%0d_cpu", r, c), cpu_gnt, (c <= 3) && (r % 2 == 1));
            check($sformatf("alt_r%0d_c%0d_dbg", r, c), dbg_gnt, (c <= 3) && (r % 2 == 0));
            check($sformatf("alt_r%0d_c%0d_busy", r, c), busy, c != 5);
            check($sformatf("alt_r%0d_c%0d_pre", r, c), dbg_preempt, 0);
            dbg_done = (c == 3) && (r % 2 == 0);
            cpu_done = (c == 3) && (r % 2 == 1);
         end
      end
      cpu_req = 1'b0; dbg_req = 1'b0;

      // burst limit 4 with CPU waiting
      dbg_req = 1'b1;
      step();
      check("burst_dbg_gnt_c1", dbg_gnt, 1);
      cpu_req = 1'b1;
      step(); step(); step();
      check("burst_dbg_gnt_c4", dbg_gnt, 1);
      check("burst_pre_c4", dbg_preempt, 0);
      step();
      check("burst_dbg_gnt_fall", dbg_gnt, 0);
      check("burst_preempt_pulse", dbg_preempt, 1);
      check("burst_cpu_gnt_hnd", cpu_gnt, 0);
      step();
      check("burst_preempt_end", dbg_preempt, 0);
      check("burst_idle_busy", busy, 0);
      step();
      check("burst_cpu_gnt", cpu_gnt, 1);
      cpu_done = 1'b1; cpu_req = 1'b0;
      step();
      cpu_done = 1'b0; dbg_req = 1'b0;
      step();

      // reset mid-DBG after a CPU release: tie must still go to CPU
      dbg_req = 1'b1;
      step(); step();
      check("pre_rst_dbg_gnt", dbg_gnt, 1);
      #1 rstn = 1'b0;
      #1;
      check("async_rst_dbg_gnt", dbg_gnt, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_preempt", dbg_preempt, 0);
      cpu_req = 1'b1;
      step();
      rstn = 1'b1;
      step();
      check("rst_release_cpu_gnt", cpu_gnt, 0);
      check("rst_release_dbg_gnt", dbg_gnt, 0);
      step();
      check("tie_after_reset_cpu", cpu_gnt, 1);
      check("tie_after_reset_dbg", dbg_gnt, 0);
      cpu_done = 1'b1; cpu_req = 1'b0;
      step();
      cpu_done = 1'b0; dbg_req = 1'b0;
      step();
      check("tie_release_idle", busy, 0);

      // dbg_done coincides with the burst limit: normal release
      dbg_req = 1'b1;
      step();
      cpu_req = 1'b1;
      step(); step(); step();
      dbg_done = 1'b1;
      step();
      check("coincide_preempt", dbg_preempt, 0);
      check("coincide_dbg_gnt", dbg_gnt, 0);
      check("coincide_busy", busy, 1);
      dbg_done = 1'b0; dbg_req = 1'b0; cpu_req = 1'b0;
      step();
      check("coincide_idle", busy, 0);

      // no CPU waiting: debug keeps ownership past the burst limit
      dbg_req = 1'b1;
      repeat (6) step();
      check("noburst_dbg_gnt_c6", dbg_gnt, 1);
      dbg_req = 1'b0;
      step();
      check("noburst_rel_gnt", dbg_gnt, 0);
      check("noburst_rel_preempt", dbg_preempt, 0);
      step();

      cpu_req = 1'b1;
      step();
`ifdef MEM_ARB_WATCHDOG_EN
      repeat (7) step();
      check("wd_cpu_gnt_c8", cpu_gnt, 1);
      check("wd_err_before", timeout_err, 0);
      step();
      check("wd_cpu_gnt_fall", cpu_gnt, 0);
      check("wd_timeout_err", timeout_err, 1);
      cpu_req = 1'b0;
      step(); step();
      check("wd_err_sticky", timeout_err, 1);
      rstn = 1'b0;
      step();
      check("wd_err_cleared", timeout_err, 0);
      rstn = 1'b1;
      step(); step();
`else
      begin
         int lows = 0;
         repeat (300) begin
            step();
            if (!cpu_gnt) lows++;
         end
         check("nowd_cpu_gnt_low_cycles", lows, 0);
         check("nowd_timeout_err", timeout_err, 0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
